// File: rtl/page_dispatcher.sv
// Splits one AXI4-Stream into whole pages and hands each page to one of N_CORES cores,
// tracking per-core outstanding pages and choosing the core by round-robin or fixed priority.
module page_dispatcher #(
  parameter int DATA_BITS       = 512,
  parameter int PAGE_SIZE       = 8192,
  parameter int N_CORES         = 6,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_BITS         = 16,
  parameter int RR_MODE         = 1,
  localparam int PAGE_BEATS      = PAGE_SIZE / (DATA_BITS / 8),
  localparam int PAGE_SIZE_WIDTH = $clog2(PAGE_BEATS + 1)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [DATA_BITS-1:0]           s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [N_CORES*DATA_BITS-1:0]   m_axis_tdata,
  output logic [N_CORES-1:0]             m_axis_tvalid,
  output logic [N_CORES-1:0]             m_axis_tlast,
  input  logic [N_CORES-1:0]             m_axis_tready,
  output logic [ID_BITS-1:0]             m_page_id,
  output logic [PAGE_SIZE_WIDTH-1:0]     m_page_beats,
  input  logic [N_CORES-1:0]             core_done,
  output logic                           credit_err,
  output logic [31:0]                    pages_sent
);

  localparam int CORE_BITS   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CREDIT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CREDIT_BITS-1:0]     CREDIT_MAX = CREDIT_BITS'(MAX_OUTSTANDING);
  localparam logic [PAGE_SIZE_WIDTH-1:0] LAST_BEAT  = PAGE_SIZE_WIDTH'(PAGE_BEATS - 1);
  localparam logic [CORE_BITS-1:0]       LAST_CORE  = CORE_BITS'(N_CORES - 1);

  typedef enum logic {
    SELECT,
    STREAM
  } state_t;

  state_t                     state_q, state_d;
  logic [CORE_BITS-1:0]       sel_q, ptr_q, pick;
  logic                       found;
  logic [PAGE_SIZE_WIDTH-1:0] beat_q;
  logic [ID_BITS-1:0]         id_q, page_id_q;
  logic [31:0]                pages_q;
  logic [CREDIT_BITS-1:0]     credit_q [N_CORES];
  logic                       err_q;
  logic [N_CORES-1:0]         eligible;
  logic                       xfer, closing, close;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CORES; i++) begin
      eligible[i] = credit_q[i] < CREDIT_MAX;
    end
  end

  // Scan order starts at the round-robin pointer, or at core 0 in fixed-priority mode.
  always_comb begin
    int idx;
    logic [CORE_BITS-1:0] cand;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (RR_MODE != 0) ? int'(ptr_q) + k : k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      cand = CORE_BITS'(idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    m_page_beats  = '0;
    closing       = 1'b0;
    xfer          = 1'b0;
    close         = 1'b0;
    case (state_q)
      SELECT: begin
        if (found) state_d = STREAM;
      end
      STREAM: begin
        closing               = (beat_q == LAST_BEAT) || s_axis_tlast;
        s_axis_tready         = m_axis_tready[sel_q];
        m_axis_tdata          = {N_CORES{s_axis_tdata}};
        m_axis_tvalid[sel_q]  = s_axis_tvalid;
        m_axis_tlast[sel_q]   = s_axis_tvalid && closing;
        if (s_axis_tvalid && closing) m_page_beats = beat_q + 1'b1;
        xfer  = s_axis_tvalid && m_axis_tready[sel_q];
        close = xfer && closing;
        if (close) state_d = SELECT;
      end
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= SELECT;
      sel_q     <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      id_q      <= '0;
      page_id_q <= '0;
      pages_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SELECT && found) begin
        sel_q     <= pick;
        page_id_q <= id_q;
      end
      if (close) begin
        beat_q  <= '0;
        id_q    <= id_q + 1'b1;
        pages_q <= pages_q + 32'd1;
        ptr_q   <= (sel_q == LAST_CORE) ? '0 : sel_q + 1'b1;
      end else if (xfer) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // A page closing on a core that also reports done in the same cycle nets to no change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_CORES; i++) credit_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (close && sel_q == CORE_BITS'(i)) begin
          if (!core_done[i]) credit_q[i] <= credit_q[i] + 1'b1;
        end else if (core_done[i]) begin
          if (credit_q[i] == '0) err_q <= 1'b1;
          else credit_q[i] <= credit_q[i] - 1'b1;
        end
      end
    end
  end

  assign m_page_id  = page_id_q;
  assign pages_sent = pages_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_page_dispatcher.sv
// Randomized bench for page_dispatcher: a round-robin instance at default sizes checked against
// a page-level credit model, plus a small fixed-priority instance for selection and reset.
`timescale 1ns/1ps
module tb_page_dispatcher;
  localparam int DW = 512, NC = 6, MAXO = 2, PB = 128, PSW = 8, IDW = 16;
  localparam int FDW = 32, FNC = 4, FPB = 8, FPSW = 4;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [DW-1:0]        s_data;
  logic                 s_valid, s_last, s_ready;
  logic [NC*DW-1:0]     m_data;
  logic [NC-1:0]        m_valid, m_last, m_ready, done;
  logic [IDW-1:0]       m_id;
  logic [PSW-1:0]       m_beats;
  logic                 err;
  logic [31:0]          sent;

  logic                 f_rstn;
  logic [FDW-1:0]       f_s_data;
  logic                 f_s_valid, f_s_last, f_s_ready;
  logic [FNC*FDW-1:0]   f_m_data;
  logic [FNC-1:0]       f_m_valid, f_m_last, f_m_ready, f_done;
  logic [IDW-1:0]       f_m_id;
  logic [FPSW-1:0]      f_m_beats;
  logic                 f_err;
  logic [31:0]          f_sent;

  int tests_run = 0;
  int tests_failed = 0;

  // Page-level reference state for the round-robin instance.
  int cred [NC];
  int ptr_m, next_id, sent_m, pending;
  bit err_m;

  page_dispatcher #(.DATA_BITS(DW), .PAGE_SIZE(8192), .N_CORES(NC), .MAX_OUTSTANDING(MAXO),
                    .ID_BITS(IDW), .RR_MODE(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .m_page_id(m_id), .m_page_beats(m_beats), .core_done(done), .credit_err(err), .pages_sent(sent)
  );

  page_dispatcher #(.DATA_BITS(FDW), .PAGE_SIZE(32), .N_CORES(FNC), .MAX_OUTSTANDING(2),
                    .ID_BITS(IDW), .RR_MODE(0)) dut_fp (
    .aclk(aclk), .aresetn(f_rstn),
    .s_axis_tdata(f_s_data), .s_axis_tvalid(f_s_valid), .s_axis_tlast(f_s_last), .s_axis_tready(f_s_ready),
    .m_axis_tdata(f_m_data), .m_axis_tvalid(f_m_valid), .m_axis_tlast(f_m_last), .m_axis_tready(f_m_ready),
    .m_page_id(f_m_id), .m_page_beats(f_m_beats), .core_done(f_done), .credit_err(f_err), .pages_sent(f_sent)
  );

  always #5 aclk = ~aclk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int rr_pick();
    for (int k = 0; k < NC; k++) begin
      if (cred[(ptr_m + k) % NC] < MAXO) return (ptr_m + k) % NC;
    end
    return -1;
  endfunction

  task automatic apply_done(input logic [NC-1:0] mask);
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        if (cred[i] == 0) err_m = 1'b1;
        else cred[i]--;
      end
    end
  endtask

  task automatic pulse_done(input logic [NC-1:0] mask);
    @(negedge aclk);
    done = mask;
    @(negedge aclk);
    done = '0;
    apply_done(mask);
    if (pending < 0) pending = rr_pick();
  endtask

  task automatic drain();
    logic [NC-1:0] mask;
    for (int r = 0; r < MAXO; r++) begin
      mask = '0;
      for (int i = 0; i < NC; i++) mask[i] = cred[i] > 0;
      if (mask != '0) pulse_done(mask);
    end
  endtask

  task automatic do_page(input int len, input bit use_last, input bit toggle, input bit gaps,
                         input logic [NC-1:0] done_close, output int idle);
    logic [DW-1:0] data [PB];
    int b, cyc, exp_core;
    bit started;
    exp_core = pending;
    idle = 0; started = 0; b = 0; cyc = 0;
    tests_run++;
    if (exp_core < 0) begin
      tests_failed++;
      $display("[TB] FAIL no_core: model has no eligible core for page id %0d", next_id);
      return;
    end
    for (int i = 0; i < len; i++)
      for (int w = 0; w < DW / 32; w++) data[i][w*32 +: 32] = $urandom;
    while (b < len && cyc < 1000) begin
      @(negedge aclk);
      s_data  = data[b];
      s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_last  = use_last && (b == len - 1);
      m_ready = '1;
      if (toggle && (cyc % 2 == 1)) m_ready[exp_core] = 1'b0;
      done = (b == len - 1 && !gaps && !toggle) ? done_close : '0;
      #1;
      tests_run++;
      if ((m_valid & ~(NC'(1) << exp_core)) !== '0) begin
        tests_failed++;
        $display("[TB] FAIL stray_valid: m_axis_tvalid=%b, only core %0d may be valid", m_valid, exp_core);
      end
      if (s_ready && s_valid) begin
        started = 1;
        tests_run += 3;
        if (m_data[exp_core*DW +: DW] !== data[b]) begin
          tests_failed++;
          $display("[TB] FAIL data: core %0d beat %0d got %h expected %h", exp_core, b,
                   m_data[exp_core*DW +: DW], data[b]);
        end
        if (m_last[exp_core] !== (b == len - 1)) begin
          tests_failed++;
          $display("[TB] FAIL tlast: core %0d beat %0d got %b expected %b", exp_core, b,
                   m_last[exp_core], (b == len - 1));
        end
        if (m_id !== IDW'(next_id)) begin
          tests_failed++;
          $display("[TB] FAIL page_id: got %0d expected %0d", m_id, next_id);
        end
        if (b == len - 1) begin
          tests_run++;
          if (m_beats !== PSW'(len)) begin
            tests_failed++;
            $display("[TB] FAIL page_beats: got %0d expected %0d", m_beats, len);
          end
        end
        b++;
      end else if (!started) begin
        idle++;
      end
      cyc++;
    end
    if (b < len) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL page_timeout: %0d of %0d beats moved to core %0d", b, len, exp_core);
    end
    @(posedge aclk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; done = '0; m_ready = '1;
    cred[exp_core]++;
    if (!gaps && !toggle) apply_done(done_close);
    next_id = (next_id + 1) % (1 << IDW);
    sent_m++;
    ptr_m = (exp_core + 1) % NC;
    pending = rr_pick();
    tests_run += 2;
    if (sent !== 32'(sent_m)) begin
      tests_failed++;
      $display("[TB] FAIL pages_sent: got %0d expected %0d", sent, sent_m);
    end
    if (err !== err_m) begin
      tests_failed++;
      $display("[TB] FAIL credit_err: got %b expected %b", err, err_m);
    end
  endtask

  task automatic check_stalled(input int ncyc);
    bit any;
    any = 0;
    repeat (ncyc) begin
      @(negedge aclk);
      s_valid = 1'b1;
      s_data  = {16{32'hDEAD_BEEF}};
      #1;
      if (s_ready) any = 1;
    end
    s_valid = 1'b0;
    tests_run++;
    if (any) begin
      tests_failed++;
      $display("[TB] FAIL stall: s_axis_tready got 1 expected 0 with every core full");
    end
  endtask

  task automatic test_reset();
    s_valid = 0; s_last = 0; m_ready = '1; done = '0;
    s_data = {16{32'h5A5A_A5A5}};
    aresetn = 1'b1;
    #1 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    tests_run += 4;
    if ({s_ready, m_valid, m_last} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: got %b expected 0", {s_ready, m_valid, m_last});
    end
    if (m_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got nonzero expected 0");
    end
    if ({m_id, m_beats} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_id: got id %0d beats %0d expected 0", m_id, m_beats);
    end
    if ({sent, err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: got sent %0d err %b expected 0", sent, err);
    end
    for (int i = 0; i < NC; i++) cred[i] = 0;
    ptr_m = 0; next_id = 0; sent_m = 0; err_m = 0;
    pending = rr_pick();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_basic();
    int idle;
    for (int p = 0; p < NC; p++) begin
      do_page(PB, 0, 0, 0, '0, idle);
      if (p > 0) begin
        tests_run++;
        if (idle !== 1) begin
          tests_failed++;
          $display("[TB] FAIL select_bubble: page %0d idle cycles got %0d expected 1", p, idle);
        end
      end
    end
  endtask

  task automatic test_credit_full();
    int idle;
    for (int p = 0; p < NC; p++) do_page(PB, 0, 0, 0, '0, idle);
    check_stalled(20);
    pulse_done(NC'(1) << 3);
    do_page(PB, 0, 0, 0, '0, idle);
  endtask

  task automatic test_short_page();
    int idle;
    drain();
    do_page(40, 1, 0, 0, '0, idle);
    do_page(PB, 0, 0, 0, '0, idle);
    do_page(PB, 1, 0, 0, '0, idle);
    do_page(10, 1, 0, 0, '0, idle);
  endtask

  task automatic test_backpressure();
    int idle;
    drain();
    do_page(PB, 0, 1, 1, '0, idle);
  endtask

  task automatic test_back_to_back();
    int idle, len;
    bit lst;
    for (int p = 0; p < 8; p++) begin
      if (pending < 0) drain();
      len = $urandom_range(2, PB);
      lst = (len < PB) ? 1'b1 : 1'($urandom_range(0, 1));
      do_page(len, lst, 0, 1'($urandom_range(0, 1)), '0, idle);
    end
  endtask

  task automatic test_done_collision();
    int idle, g;
    drain();
    g = 0;
    while (pending != 0 && g < 10) begin
      do_page(3, 1, 0, 0, '0, idle);
      drain();
      g++;
    end
    do_page(3, 1, 0, 0, '0, idle);
    for (int p = 1; p < NC; p++) do_page(3, 1, 0, 0, '0, idle);
    do_page(3, 1, 0, 0, NC'(1), idle);
    g = 0;
    while (pending >= 0 && g < 20) begin
      do_page(3, 1, 0, 0, '0, idle);
      g++;
    end
    check_stalled(10);
  endtask

  task automatic test_credit_err();
    int idle;
    drain();
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_clear: credit_err got %b expected 0", err);
    end
    pulse_done(NC'(1) << 4);
    #1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_set: credit_err got %b expected 1", err);
    end
    do_page(PB, 0, 0, 0, '0, idle);
    repeat (5) @(negedge aclk);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: credit_err got %b expected 1", err);
    end
  endtask

  task automatic fp_page(input int exp_core, input int exp_id);
    logic [FDW-1:0] d [FPB];
    int b, cyc;
    b = 0; cyc = 0;
    for (int i = 0; i < FPB; i++) d[i] = $urandom;
    while (b < FPB && cyc < 100) begin
      @(negedge aclk);
      f_s_data = d[b]; f_s_valid = 1'b1; f_s_last = 1'b0;
      #1;
      tests_run++;
      if ((f_m_valid & ~(FNC'(1) << exp_core)) !== '0) begin
        tests_failed++;
        $display("[TB] FAIL fp_stray_valid: got %b expected only core %0d", f_m_valid, exp_core);
      end
      if (f_s_ready) begin
        tests_run += 3;
        if (f_m_data[exp_core*FDW +: FDW] !== d[b]) begin
          tests_failed++;
          $display("[TB] FAIL fp_data: core %0d beat %0d got %h expected %h", exp_core, b,
                   f_m_data[exp_core*FDW +: FDW], d[b]);
        end
        if (f_m_last[exp_core] !== (b == FPB - 1)) begin
          tests_failed++;
          $display("[TB] FAIL fp_tlast: beat %0d got %b expected %b", b, f_m_last[exp_core], (b == FPB - 1));
        end
        if (f_m_id !== IDW'(exp_id)) begin
          tests_failed++;
          $display("[TB] FAIL fp_page_id: got %0d expected %0d", f_m_id, exp_id);
        end
        if (b == FPB - 1) begin
          tests_run++;
          if (f_m_beats !== FPSW'(FPB)) begin
            tests_failed++;
            $display("[TB] FAIL fp_page_beats: got %0d expected %0d", f_m_beats, FPB);
          end
        end
        b++;
      end
      cyc++;
    end
    if (b < FPB) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL fp_timeout: %0d of %0d beats to core %0d", b, FPB, exp_core);
    end
    @(posedge aclk);
    #1;
    f_s_valid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    int fc [FNC];
    int c, b, cyc;
    for (int i = 0; i < FNC; i++) fc[i] = 0;
    @(negedge aclk);
    f_rstn = 1'b1;
    for (int p = 0; p < 5; p++) begin
      c = -1;
      for (int i = FNC - 1; i >= 0; i--) if (fc[i] < 2) c = i;
      fp_page(c, p);
      fc[c]++;
    end
    b = 0; cyc = 0;
    while (b < 3 && cyc < 50) begin
      @(negedge aclk);
      f_s_valid = 1'b1; f_s_data = $urandom;
      #1;
      if (f_s_ready) b++;
      cyc++;
    end
    @(negedge aclk);
    #2 f_rstn = 1'b0;
    #1;
    tests_run += 3;
    if ({f_s_ready, f_m_valid, f_m_last} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL fp_reset_handshake: got %b expected 0", {f_s_ready, f_m_valid, f_m_last});
    end
    if ({f_m_data, f_m_beats} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL fp_reset_data: got %h expected 0", {f_m_data, f_m_beats});
    end
    if ({f_m_id, f_sent, f_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL fp_reset_counters: got id %0d sent %0d err %b expected 0", f_m_id, f_sent, f_err);
    end
    @(negedge aclk);
    f_s_valid = 1'b0;
    f_rstn = 1'b1;
    fp_page(0, 0);
    tests_run++;
    if (f_sent !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL fp_pages_sent: got %0d expected 1", f_sent);
    end
  endtask

  initial begin
    f_rstn = 1'b1;
    f_s_data = '0; f_s_valid = 1'b0; f_s_last = 1'b0; f_m_ready = '1; f_done = '0;
    #1 f_rstn = 1'b0;
    test_reset();
    test_basic();
    test_credit_full();
    test_short_page();
    test_backpressure();
    test_back_to_back();
    test_done_collision();
    test_credit_err();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
